// File: rtl/dm_pkg.sv
// Shared types and constants for the data-memory responder.
package dm_pkg;

    localparam int unsigned ADDR_W  = 5;
    localparam int unsigned COUNT_W = 16;

    localparam logic DM_READ  = 1'b0;
    localparam logic DM_WRITE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } dm_state_e;

endpackage

// File: rtl/dm_storage.sv
// Synchronous word array: one write port and one registered read port on a shared address.
// Out-of-range addresses neither write nor read (read returns zero).
module dm_storage
    import dm_pkg::*;
#(
    parameter int unsigned WORDSIZE = 64,
    parameter int unsigned SIZE     = 32
) (
    input  logic                clk,
    input  logic                we,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [WORDSIZE-1:0] wdata,
    output logic [WORDSIZE-1:0] rdata
);

    localparam int unsigned IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;

    logic [WORDSIZE-1:0] mem [SIZE];
    logic [IDX_W-1:0]    idx;
    logic                addr_ok;

    assign idx     = addr[IDX_W-1:0];
    assign addr_ok = (32'(addr) < SIZE);

    // Write commit and registered read, both guarded against out-of-range addresses.
    always_ff @(posedge clk) begin
        if (we && addr_ok) begin
            mem[idx] <= wdata;
        end
        if (addr_ok) begin
            rdata <= mem[idx];
        end else begin
            rdata <= '0;
        end
    end

endmodule

// File: rtl/dm_responder.sv
// Memory-side responder: accepts one read/write at a time, performs it on local storage and
// returns a response under backpressure. Counts completed responses, saturating.
module dm_responder
    import dm_pkg::*;
#(
    parameter int unsigned WORDSIZE = 64,
    parameter int unsigned SIZE     = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [WORDSIZE-1:0] req_wdata,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [WORDSIZE-1:0] resp_rdata,
    output logic                resp_err,
    output logic [COUNT_W-1:0]  access_count
);

    dm_state_e           state_q;
    logic                write_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [WORDSIZE-1:0] wdata_q;
    logic [COUNT_W-1:0]  count_q;

    logic                addr_ok;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [WORDSIZE-1:0] mem_rdata;

    assign addr_ok = (32'(addr_q) < SIZE);

    // In IDLE the storage reads the incoming address, so the word is already registered when
    // the FSM reaches ACCESS; afterwards the captured address drives the write.
    assign mem_addr = (state_q == ST_IDLE) ? req_addr : addr_q;

    // Reset on the ACCESS edge must suppress the pending write.
    assign mem_we = !rst && (state_q == ST_ACCESS) && (write_q == DM_WRITE) && addr_ok;

    assign access_count = count_q;

    dm_storage #(
        .WORDSIZE (WORDSIZE),
        .SIZE     (SIZE)
    ) u_storage (
        .clk   (clk),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (wdata_q),
        .rdata (mem_rdata)
    );

    // Request/response FSM with registered handshake outputs, capture registers and counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            count_q    <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        write_q   <= req_write;
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        req_ready <= 1'b0;
                        state_q   <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (addr_ok) begin
                        resp_rdata <= (write_q == DM_WRITE) ? '0 : mem_rdata;
                        resp_err   <= 1'b0;
                    end else begin
                        resp_rdata <= '0;
                        resp_err   <= 1'b1;
                    end
                    resp_valid <= 1'b1;
                    state_q    <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        if (count_q != '1) begin
                            count_q <= count_q + 1'b1;
                        end
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    state_q    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder, built with SIZE = 16 so out-of-range requests can occur.
module tb_dm_responder;

    localparam int unsigned WORDSIZE = 64;
    localparam int unsigned SIZE     = 16;

    logic                clk;
    logic                rst;
    logic                req_valid;
    logic                req_ready;
    logic                req_write;
    logic [4:0]          req_addr;
    logic [WORDSIZE-1:0] req_wdata;
    logic                resp_valid;
    logic                resp_ready;
    logic [WORDSIZE-1:0] resp_rdata;
    logic                resp_err;
    logic [15:0]         access_count;

    int total;
    int bad;

    dm_responder #(
        .WORDSIZE (WORDSIZE),
        .SIZE     (SIZE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .access_count (access_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are driven and outputs sampled 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full transaction with no backpressure; checks latency and handshake timing.
    task automatic txn(input logic wr, input logic [4:0] a, input logic [63:0] d,
                       output logic [63:0] rd, output logic er);
        req_valid  = 1'b1;
        req_write  = wr;
        req_addr   = a;
        req_wdata  = d;
        resp_ready = 1'b1;
        step();
        req_valid = 1'b0;
        check("acc_ready", 64'(req_ready), 64'd0);
        check("acc_valid", 64'(resp_valid), 64'd0);
        step();
        check("resp_latency", 64'(resp_valid), 64'd1);
        rd = resp_rdata;
        er = resp_err;
        step();
        check("hs_valid", 64'(resp_valid), 64'd0);
        check("hs_ready", 64'(req_ready), 64'd1);
    endtask

    logic [63:0] rd;
    logic        er;
    int          seen;
    int          cyc [3];
    logic [63:0] dat [3];

    initial begin
        total      = 0;
        bad        = 0;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = 1'b0;
        step();
        step();
        rst = 1'b0;

        // Reset state
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_rdata", resp_rdata, 64'd0);
        check("rst_err", 64'(resp_err), 64'd0);
        check("rst_count", 64'(access_count), 64'd0);

        // Write then read
        txn(1'b1, 5'd5, 64'hDEADBEEF_00000001, rd, er);
        check("wr5_rdata", rd, 64'd0);
        check("wr5_err", 64'(er), 64'd0);
        txn(1'b0, 5'd5, 64'd0, rd, er);
        check("rd5_rdata", rd, 64'hDEADBEEF_00000001);
        check("rd5_err", 64'(er), 64'd0);
        check("count_2", 64'(access_count), 64'd2);

        // Response backpressure on a read of addr 0
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_addr   = 5'd0;
        resp_ready = 1'b0;
        step();
        req_valid = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            check("bp_valid", 64'(resp_valid), 64'd1);
            check("bp_rdata", resp_rdata, 64'd0);
            check("bp_ready", 64'(req_ready), 64'd0);
            check("bp_count", 64'(access_count), 64'd2);
            step();
        end
        resp_ready = 1'b1;
        step();
        check("bp_hs_valid", 64'(resp_valid), 64'd0);
        check("bp_hs_count", 64'(access_count), 64'd3);

        // Out-of-range write must not touch storage (addr 20 aliases to 4 in the low bits)
        txn(1'b1, 5'd20, 64'h1, rd, er);
        check("oor_wr_err", 64'(er), 64'd1);
        check("oor_wr_rdata", rd, 64'd0);
        for (int a = 0; a < 16; a++) begin
            txn(1'b0, 5'(a), 64'd0, rd, er);
            check("scan_rdata", rd, (a == 5) ? 64'hDEADBEEF_00000001 : 64'd0);
            check("scan_err", 64'(er), 64'd0);
        end
        txn(1'b0, 5'd20, 64'd0, rd, er);
        check("oor_rd_err", 64'(er), 64'd1);
        check("oor_rd_rdata", rd, 64'd0);
        check("count_21", 64'(access_count), 64'd21);

        // Reset on the ACCESS edge drops the write
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_addr   = 5'd3;
        req_wdata  = 64'hAAAA;
        resp_ready = 1'b1;
        step();
        req_valid = 1'b0;
        rst       = 1'b1;
        step();
        rst = 1'b0;
        check("rsta_req_ready", 64'(req_ready), 64'd1);
        check("rsta_resp_valid", 64'(resp_valid), 64'd0);
        check("rsta_count", 64'(access_count), 64'd0);
        txn(1'b0, 5'd3, 64'd0, rd, er);
        check("rsta_rd3", rd, 64'd0);

        txn(1'b1, 5'd1, 64'h11, rd, er);
        txn(1'b1, 5'd2, 64'h22, rd, er);
        check("count_3", 64'(access_count), 64'd3);

        // Held req_valid: reads of 1, 2, 3 back to back, one response every 3 edges
        seen       = 0;
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_addr   = 5'd1;
        resp_ready = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (resp_valid) begin
                if (seen < 3) begin
                    cyc[seen] = k;
                    dat[seen] = resp_rdata;
                end
                seen++;
                if (seen >= 3) begin
                    req_valid = 1'b0;
                end else begin
                    req_addr = 5'(seen + 1);
                end
            end
        end
        req_valid = 1'b0;
        check("held_n", 64'(seen), 64'd3);
        check("held_cyc0", 64'(cyc[0]), 64'd2);
        check("held_cyc1", 64'(cyc[1]), 64'd5);
        check("held_cyc2", 64'(cyc[2]), 64'd8);
        check("held_d0", dat[0], 64'h11);
        check("held_d1", dat[1], 64'h22);
        check("held_d2", dat[2], 64'd0);
        check("count_6", 64'(access_count), 64'd6);

        // Reset while in RESP drops the response without counting it
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_addr   = 5'd1;
        resp_ready = 1'b0;
        step();
        req_valid = 1'b0;
        step();
        check("rstr_valid_pre", 64'(resp_valid), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rstr_valid", 64'(resp_valid), 64'd0);
        check("rstr_ready", 64'(req_ready), 64'd1);
        check("rstr_count", 64'(access_count), 64'd0);
        check("rstr_rdata", resp_rdata, 64'd0);

        // Counter saturation starting from a preset near the top
        force dut.count_q = 16'hFFFE;
        #1;
        release dut.count_q;
        check("sat_preset", 64'(access_count), 64'hFFFE);
        txn(1'b0, 5'd1, 64'd0, rd, er);
        check("sat_ffff", 64'(access_count), 64'hFFFF);
        txn(1'b0, 5'd2, 64'd0, rd, er);
        check("sat_hold", 64'(access_count), 64'hFFFF);
        check("sat_rdata", rd, 64'h22);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
